// File: rtl/ndp_pkg.sv
// ndp_pkg: definitions shared across the NDP compute slice.
//   - drain_state_t : result-drain FSM encoding (IDLE, STREAM)
//   - clog2         : ceiling log2, also used by the compute unit and controller
//   - n_elem        : elements in one result tile of the systolic grid
//   - beats         : output beats needed to stream one tile
//   - idx_width     : beat-counter width, never narrower than one bit
package ndp_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } drain_state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int n_elem(input int arr_width, input int arr_height,
                                  input int sys_width, input int sys_height);
        return arr_width * arr_height * sys_width * sys_height;
    endfunction

    function automatic int beats(input int elems, input int lanes);
        return elems / lanes;
    endfunction

    function automatic int idx_width(input int n_beats);
        return (clog2(n_beats) < 1) ? 1 : clog2(n_beats);
    endfunction

endpackage

// File: rtl/ndp_result_drain_if.sv
// ndp_result_drain_if: valid/ready beat stream from the result drain to write-back.
//   out_valid : beat available           (master -> slave)
//   out_ready : consumer accepts beat    (slave  -> master)
//   out_data  : LANES*WIDTH beat payload (master -> slave)
//   out_idx   : beat number within tile  (master -> slave)
//   out_last  : final beat of the tile   (master -> slave)
interface ndp_result_drain_if #(
    parameter int LANES = 16,
    parameter int WIDTH = 16,
    parameter int IDX_W = 6
);
    logic                   out_valid;
    logic                   out_ready;
    logic [LANES*WIDTH-1:0] out_data;
    logic [IDX_W-1:0]       out_idx;
    logic                   out_last;

    modport master (
        output out_valid, out_data, out_idx, out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_data, out_idx, out_last,
        output out_ready
    );
endinterface

// File: rtl/ndp_result_drain.sv
// ndp_result_drain: captures a full result tile on a rising edge of
// calc_done_flag and streams it out as OUT_LANES-element beats.
//   clk            : clock, all state on rising edge
//   reset          : asynchronous active-high reset
//   calc_done_flag : level "tile complete" from the compute unit
//   in_c           : result tile, element e at in_c[e*WIDTH +: WIDTH]
//   busy           : a captured tile is still being drained
//   overrun        : sticky, a completion was dropped while draining
//   dout           : beat stream (valid/ready, data, idx, last)
module ndp_result_drain
    import ndp_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int ARR_WIDTH  = 4,
    parameter int ARR_HEIGHT = 4,
    parameter int SYS_WIDTH  = 64,
    parameter int SYS_HEIGHT = 1,
    parameter int OUT_LANES  = 16,
    localparam int N_ELEM    = n_elem(ARR_WIDTH, ARR_HEIGHT, SYS_WIDTH, SYS_HEIGHT),
    localparam int BEATS     = beats(N_ELEM, OUT_LANES),
    localparam int IDX_W     = idx_width(BEATS)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    calc_done_flag,
    input  logic [N_ELEM*WIDTH-1:0] in_c,
    output logic                    busy,
    output logic                    overrun,
    ndp_result_drain_if.master      dout
);

    localparam int BEAT_W = OUT_LANES * WIDTH;
    localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(BEATS - 1);

    drain_state_t            state_reg, state_next;
    logic [IDX_W-1:0]        beat_reg, beat_next;
    logic                    flag_q_reg;
    logic                    overrun_reg, overrun_next;
    logic                    capture;
    logic                    trigger;
    logic                    handshake;
    logic                    final_hs;
    logic [N_ELEM*WIDTH-1:0] tile_reg;
    logic [BEAT_W-1:0]       beat_words [BEATS];

    // flag_q resets high so a flag already asserted at reset release is
    // not mistaken for a fresh completion.
    assign trigger   = calc_done_flag & ~flag_q_reg;
    assign handshake = (state_reg == STREAM) & dout.out_ready;
    assign final_hs  = handshake & (beat_reg == LAST_BEAT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            beat_reg    <= '0;
            flag_q_reg  <= 1'b1;
            overrun_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            beat_reg    <= beat_next;
            flag_q_reg  <= calc_done_flag;
            overrun_reg <= overrun_next;
        end
    end

    // The tile buffer needs no reset: it is only read while in STREAM,
    // which is reachable only through a capture.
    always_ff @(posedge clk) begin
        if (capture) begin
            tile_reg <= in_c;
        end
    end

    always_comb begin
        state_next   = state_reg;
        beat_next    = beat_reg;
        overrun_next = overrun_reg;
        capture      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (trigger) begin
                    capture    = 1'b1;
                    beat_next  = '0;
                    state_next = STREAM;
                end
            end
            STREAM: begin
                if (final_hs) begin
                    beat_next = '0;
                    // A completion coinciding with the last handshake
                    // chains straight into the next tile with no bubble.
                    if (trigger) begin
                        capture = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    if (handshake) begin
                        beat_next = beat_reg + IDX_W'(1);
                    end
                    if (trigger) begin
                        overrun_next = 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Slice the buffer into beats so the output mux is a plain array index.
    for (genvar gi = 0; gi < BEATS; gi++) begin : g_beat
        assign beat_words[gi] = tile_reg[gi*BEAT_W +: BEAT_W];
    end

    assign busy           = (state_reg == STREAM);
    assign overrun        = overrun_reg;
    assign dout.out_valid = busy;
    assign dout.out_data  = busy ? beat_words[beat_reg] : '0;
    assign dout.out_idx   = busy ? beat_reg : '0;
    assign dout.out_last  = busy & (beat_reg == LAST_BEAT);

endmodule
